ising_readout: RTL and testbench
================================

# ising_readout

Downstream stage of the Ising oscillator machine. It captures the final phase vector when the machine pulses `done`, binarizes each phase into a spin, and evaluates the Ising energy E = -Σ_{i<j} J[i][j]·s_i·s_j one pair per cycle. It tracks the lowest-energy spin configuration across successive anneal runs, which lets the host restart the machine and keep the best solution found.

## Interface
Parameters:
- `N`, 16: number of spins; must match the oscillator machine.
- `DATA_WIDTH`, 32: width of phases and couplings, signed Q16.16.
- `ENERGY_WIDTH`, 48: width of the signed energy accumulator, Q32.16.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `phi_in[N]`, in, DATA_WIDTH each: final phases from the machine's `phi_out`.
- `phi_valid`, in, 1: one-cycle pulse, driven from the machine's `done`.
- `J[N][N]`, in, DATA_WIDTH each: coupling matrix, held stable during a run. Only entries with i<j are read.
- `clear_best`, in, 1: clears best tracking and `overrun`.
- `spins`, out, N: bit k is 1 when s_k = +1 and 0 when s_k = -1.
- `energy`, out, ENERGY_WIDTH: energy of the last completed run.
- `energy_valid`, out, 1: one-cycle pulse when `energy` and `spins` update.
- `busy`, out, 1: high while evaluating.
- `best_spins`, out, N: lowest-energy configuration seen.
- `best_energy`, out, ENERGY_WIDTH: its energy.
- `best_valid`, out, 1: the `best_*` outputs hold a recorded run.
- `run_count`, out, 16: completed runs, saturating at 0xFFFF.
- `overrun`, out, 1: sticky; a `phi_valid` arrived while the block was busy.

## Operation
- Spin rule: s_k = +1 iff -HALF_PI ≤ phi_in[k] ≤ HALF_PI, with HALF_PI = 0x00019220. Both bounds are inclusive. Otherwise s_k = -1.
- States: IDLE, ACCUM, FINISH.
- IDLE, when `phi_valid`=1: latch spins from `phi_in`, set acc=0, set (i,j)=(0,1), go to ACCUM.
- ACCUM: each cycle processes pair (i,j).
  - If s_i==s_j, acc -= sext(J[i][j]); otherwise acc += sext(J[i][j]).
  - Advance j. When j reaches N-1, advance i and set j=i+1.
  - After the pair (N-2,N-1), go to FINISH.
- FINISH:
  - `energy` ← acc and `spins` ← latched spins.
  - Pulse `energy_valid`. Increment `run_count` (saturating).
  - If `best_valid`=0 or acc < `best_energy` (signed, strict), load `best_*` and set `best_valid`=1. On a tie the earlier run is kept.
  - Return to IDLE.
- `clear_best` in any state sets `best_valid`=0, `best_energy`=max positive, `best_spins`=0 and `overrun`=0.
  - If `clear_best` coincides with FINISH, the clear wins. That run still updates `energy`, `spins` and `run_count`, but it is not recorded as best.
- `phi_valid` in ACCUM or FINISH is ignored and sets `overrun`. The run in progress is unaffected.
- Sign extension: J is sign-extended to ENERGY_WIDTH, with no scaling, so the accumulator stays Q32.16. No saturation is applied; the 48-bit width covers N ≤ 256 at full-scale J.

## Timing
- Reset values:
  - `spins`, `energy`, `run_count`, `best_spins`: 0.
  - `energy_valid`, `busy`, `best_valid`, `overrun`: 0.
  - `best_energy`: 0x7FFF_FFFF_FFFF.
  - State: IDLE.
- Pair count P = N(N-1)/2, which is 120 for N=16.
- Let `phi_valid` be sampled in cycle t0.
  - ACCUM runs in cycles t0+1 … t0+P.
  - FINISH runs in cycle t0+P+1.
  - `energy_valid` is high in cycle t0+P+2.
  - Latency is therefore P+2 cycles (122 for N=16).
- `busy` is high in cycles t0+1 … t0+P+1.
- A new `phi_valid` is accepted in the same cycle that `energy_valid` is high.
- `best_*` and `run_count` update on the same edge as `energy`.
- Asserting `rst` mid-run aborts the run. All outputs take their reset values on the next edge, and a partial result is never reported.

## Test plan
- N=4, J[0][1]=0x10000 and all other J=0, phi all 0 → `spins`=4'b1111, `energy`=0xFFFF_FFFF_0000 (-1.0), `energy_valid` exactly 8 cycles after `phi_valid`, `best_valid`=1.
- Same J, then phi[1]=0x3243F → `spins`=4'b1101, `energy`=0x0000_0001_0000. `best_energy` remains -1.0 with `best_spins`=4'b1111, and `run_count`=2.
- Boundaries: phi=0x19220 → spin 1; 0x19221 → spin 0; 0xFFFE6DE0 (-HALF_PI) → spin 1; 0xFFFE6DDF → spin 0.
- `phi_valid` pulsed in the 3rd ACCUM cycle → `overrun`=1, the result matches a clean run, and no extra `energy_valid` pulse occurs.
- `rst` asserted mid-ACCUM → all outputs are at reset values on the next cycle. A following run produces the correct energy, with `run_count`=1.
- `clear_best` in the FINISH cycle, and a repeat run with equal energy → `best_valid`=0 after the clear. The tie run then records, because `best_valid` was 0.

Source files
------------

// File: rtl/ising_readout_if.sv
// Bundle between the oscillator machine/host and the Ising readout stage.
// The master drives phases, couplings and control; the slave returns results.
interface ising_readout_if #(
    parameter int unsigned N            = 16,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ENERGY_WIDTH = 48
);
    logic [N-1:0][DATA_WIDTH-1:0]        phi_in;
    logic                                phi_valid;
    logic [N-1:0][N-1:0][DATA_WIDTH-1:0] J;
    logic                                clear_best;
    logic [N-1:0]                        spins;
    logic [ENERGY_WIDTH-1:0]             energy;
    logic                                energy_valid;
    logic                                busy;
    logic [N-1:0]                        best_spins;
    logic [ENERGY_WIDTH-1:0]             best_energy;
    logic                                best_valid;
    logic [15:0]                         run_count;
    logic                                overrun;

    modport master (
        output phi_in, phi_valid, J, clear_best,
        input  spins, energy, energy_valid, busy, best_spins, best_energy, best_valid,
               run_count, overrun
    );

    modport slave (
        input  phi_in, phi_valid, J, clear_best,
        output spins, energy, energy_valid, busy, best_spins, best_energy, best_valid,
               run_count, overrun
    );
endinterface

// File: rtl/ising_readout.sv
// Binarizes captured oscillator phases into spins, accumulates the Ising energy one
// coupling pair per cycle, and keeps the lowest-energy configuration across runs.
module ising_readout #(
    parameter int unsigned N            = 16,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ENERGY_WIDTH = 48
) (
    input logic            clk,
    input logic            rst,
    ising_readout_if.slave bus
);
    localparam int unsigned IdxW = $clog2(N);
    localparam logic [IdxW-1:0] LastJ = IdxW'(N - 1);
    localparam logic [IdxW-1:0] LastI = IdxW'(N - 2);
    localparam logic signed [DATA_WIDTH-1:0] HalfPi    = DATA_WIDTH'(32'sh0001_9220);
    localparam logic signed [DATA_WIDTH-1:0] NegHalfPi = -HalfPi;
    localparam logic signed [ENERGY_WIDTH-1:0] EnergyMax = {1'b0, {(ENERGY_WIDTH - 1){1'b1}}};

    typedef enum logic [1:0] {StIdle, StAccum, StFinish} state_e;

    state_e                         state_q;
    logic [IdxW-1:0]                i_q, j_q;
    logic [N-1:0]                   spin_q;
    logic signed [ENERGY_WIDTH-1:0] acc_q;
    logic [N-1:0]                   spins_q;
    logic signed [ENERGY_WIDTH-1:0] energy_q;
    logic                           energy_valid_q;
    logic                           busy_q;
    logic [N-1:0]                   best_spins_q;
    logic signed [ENERGY_WIDTH-1:0] best_energy_q;
    logic                           best_valid_q;
    logic [15:0]                    run_count_q;
    logic                           overrun_q;

    logic [N-1:0]                   phi_spin;
    logic [DATA_WIDTH-1:0]          j_raw;
    logic signed [ENERGY_WIDTH-1:0] j_ext;

    // Spin is +1 when the phase lies within [-pi/2, +pi/2], both bounds inclusive.
    always_comb begin
        phi_spin = '0;
        for (int unsigned k = 0; k < N; k++) begin
            phi_spin[k] = ($signed(bus.phi_in[k]) >= NegHalfPi) &&
                          ($signed(bus.phi_in[k]) <= HalfPi);
        end
    end

    always_comb begin
        j_raw = bus.J[i_q][j_q];
        j_ext = {{(ENERGY_WIDTH - DATA_WIDTH){j_raw[DATA_WIDTH-1]}}, j_raw};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            i_q            <= '0;
            j_q            <= '0;
            spin_q         <= '0;
            acc_q          <= '0;
            spins_q        <= '0;
            energy_q       <= '0;
            energy_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            best_spins_q   <= '0;
            best_energy_q  <= EnergyMax;
            best_valid_q   <= 1'b0;
            run_count_q    <= '0;
            overrun_q      <= 1'b0;
        end else begin
            energy_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.phi_valid) begin
                        spin_q  <= phi_spin;
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= IdxW'(1);
                        busy_q  <= 1'b1;
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    if (bus.phi_valid) overrun_q <= 1'b1;
                    // Aligned spins lower the energy by J, anti-aligned raise it.
                    if (spin_q[i_q] == spin_q[j_q]) acc_q <= acc_q - j_ext;
                    else                            acc_q <= acc_q + j_ext;
                    if (j_q == LastJ) begin
                        if (i_q == LastI) begin
                            state_q <= StFinish;
                        end else begin
                            i_q <= i_q + IdxW'(1);
                            j_q <= i_q + IdxW'(2);
                        end
                    end else begin
                        j_q <= j_q + IdxW'(1);
                    end
                end
                StFinish: begin
                    if (bus.phi_valid) overrun_q <= 1'b1;
                    energy_q       <= acc_q;
                    spins_q        <= spin_q;
                    energy_valid_q <= 1'b1;
                    busy_q         <= 1'b0;
                    if (run_count_q != 16'hFFFF) run_count_q <= run_count_q + 16'd1;
                    // Strict compare keeps the earlier run on a tie.
                    if (!best_valid_q || (acc_q < best_energy_q)) begin
                        best_energy_q <= acc_q;
                        best_spins_q  <= spin_q;
                        best_valid_q  <= 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            if (bus.clear_best) begin
                best_valid_q  <= 1'b0;
                best_energy_q <= EnergyMax;
                best_spins_q  <= '0;
                overrun_q     <= 1'b0;
            end
        end
    end

    assign bus.spins        = spins_q;
    assign bus.energy       = energy_q;
    assign bus.energy_valid = energy_valid_q;
    assign bus.busy         = busy_q;
    assign bus.best_spins   = best_spins_q;
    assign bus.best_energy  = best_energy_q;
    assign bus.best_valid   = best_valid_q;
    assign bus.run_count    = run_count_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_ising_readout.sv
// Directed bench for ising_readout at N=4: table of runs with hand-computed energies,
// plus sequences for overrun, mid-run reset and clear_best in the FINISH cycle.
module tb_ising_readout;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned EW = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ising_readout_if #(.N(N), .DATA_WIDTH(DW), .ENERGY_WIDTH(EW)) bus ();

    ising_readout #(.N(N), .DATA_WIDTH(DW), .ENERGY_WIDTH(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0][31:0] phi;         // {phi3, phi2, phi1, phi0}
        logic [5:0][31:0] jp;          // {J23, J13, J12, J03, J02, J01}
        logic [3:0]       spins;
        logic [47:0]      energy;
        logic [3:0]       best_spins;
        logic [47:0]      best_energy;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [3:0][31:0] phi, input logic [5:0][31:0] jp);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                bus.J[r][c] = 32'h1234_5678;  // lower triangle must be ignored
        bus.J[0][1] = jp[0];
        bus.J[0][2] = jp[1];
        bus.J[0][3] = jp[2];
        bus.J[1][2] = jp[3];
        bus.J[1][3] = jp[4];
        bus.J[2][3] = jp[5];
        bus.phi_in  = phi;
    endtask

    // Pulse phi_valid, then watch 14 cycles; cycle numbers count from the phi_valid cycle.
    task automatic run_window(input int inj_at, input int clr_at, output int lat,
                              output int pulses, output int busy_err);
        int cyc;
        lat = -1;
        pulses = 0;
        busy_err = 0;
        bus.phi_valid = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1;
        while (cyc <= 14) begin
            bus.phi_valid  = (cyc == inj_at);
            bus.clear_best = (cyc == clr_at);
            @(negedge clk);
            if (bus.energy_valid === 1'b1) begin
                pulses++;
                if (lat < 0) lat = cyc;
            end
            if (bus.busy !== 1'(cyc <= 7)) busy_err++;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.phi_valid  = 1'b0;
        bus.clear_best = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_spins", 64'(bus.spins), 64'h0);
        check("rst_energy", 64'(bus.energy), 64'h0);
        check("rst_energy_valid", 64'(bus.energy_valid), 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_best_spins", 64'(bus.best_spins), 64'h0);
        check("rst_best_energy", 64'(bus.best_energy), 64'h7FFF_FFFF_FFFF);
        check("rst_best_valid", 64'(bus.best_valid), 64'h0);
        check("rst_run_count", 64'(bus.run_count), 64'h0);
        check("rst_overrun", 64'(bus.overrun), 64'h0);
    endtask

    initial begin
        int lat, pulses, busy_err, stray;

        vecs[0] = '{phi: {32'h0, 32'h0, 32'h0, 32'h0},
                    jp: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0001_0000},
                    spins: 4'b1111, energy: 48'hFFFF_FFFF_0000,
                    best_spins: 4'b1111, best_energy: 48'hFFFF_FFFF_0000};
        vecs[1] = '{phi: {32'h0, 32'h0, 32'h0003_243F, 32'h0},
                    jp: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0001_0000},
                    spins: 4'b1101, energy: 48'h0000_0001_0000,
                    best_spins: 4'b1111, best_energy: 48'hFFFF_FFFF_0000};
        vecs[2] = '{phi: {32'hFFFE_6DDF, 32'hFFFE_6DE0, 32'h0001_9221, 32'h0001_9220},
                    jp: {6{32'h0001_0000}},
                    spins: 4'b0101, energy: 48'h0000_0002_0000,
                    best_spins: 4'b1111, best_energy: 48'hFFFF_FFFF_0000};
        vecs[3] = '{phi: {4{32'h0008_0000}},
                    jp: {32'h0002_8000, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_0000},
                    spins: 4'b0000, energy: 48'hFFFF_FFFE_8000,
                    best_spins: 4'b0000, best_energy: 48'hFFFF_FFFE_8000};
        vecs[4] = '{phi: {4{32'h0}},
                    jp: {6{32'h7FFF_FFFF}},
                    spins: 4'b1111, energy: 48'hFFFD_0000_0006,
                    best_spins: 4'b1111, best_energy: 48'hFFFD_0000_0006};
        vecs[5] = '{phi: {32'h0008_0000, 32'h0, 32'h0008_0000, 32'h0},
                    jp: {6{32'h8000_0000}},
                    spins: 4'b0101, energy: 48'hFFFF_0000_0000,
                    best_spins: 4'b1111, best_energy: 48'hFFFD_0000_0006};

        bus.phi_valid  = 1'b0;
        bus.clear_best = 1'b0;
        load('0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1;

        foreach (vecs[v]) begin
            load(vecs[v].phi, vecs[v].jp);
            run_window(-1, -1, lat, pulses, busy_err);
            check($sformatf("v%0d_latency", v), 64'(lat), 64'd8);
            check($sformatf("v%0d_pulses", v), 64'(pulses), 64'd1);
            check($sformatf("v%0d_busy", v), 64'(busy_err), 64'd0);
            check($sformatf("v%0d_spins", v), 64'(bus.spins), 64'(vecs[v].spins));
            check($sformatf("v%0d_energy", v), 64'(bus.energy), 64'(vecs[v].energy));
            check($sformatf("v%0d_best_valid", v), 64'(bus.best_valid), 64'h1);
            check($sformatf("v%0d_best_spins", v), 64'(bus.best_spins),
                  64'(vecs[v].best_spins));
            check($sformatf("v%0d_best_energy", v), 64'(bus.best_energy),
                  64'(vecs[v].best_energy));
            check($sformatf("v%0d_run_count", v), 64'(bus.run_count), 64'(v + 1));
        end

        // Second phi_valid in the third ACCUM cycle is flagged but otherwise ignored.
        load(vecs[0].phi, vecs[0].jp);
        run_window(3, -1, lat, pulses, busy_err);
        check("ovr_latency", 64'(lat), 64'd8);
        check("ovr_pulses", 64'(pulses), 64'd1);
        check("ovr_energy", 64'(bus.energy), 64'hFFFF_FFFF_0000);
        check("ovr_overrun", 64'(bus.overrun), 64'h1);
        check("ovr_run_count", 64'(bus.run_count), 64'd7);
        check("ovr_best_energy", 64'(bus.best_energy), 64'hFFFD_0000_0006);

        // Reset in the third ACCUM cycle aborts the run.
        bus.phi_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.phi_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state();
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.energy_valid !== 1'b0) stray++;
        end
        check("rst_no_stray_result", 64'(stray), 64'd0);
        @(posedge clk);
        #1;
        load(vecs[1].phi, vecs[1].jp);
        run_window(-1, -1, lat, pulses, busy_err);
        check("post_rst_latency", 64'(lat), 64'd8);
        check("post_rst_energy", 64'(bus.energy), 64'h0000_0001_0000);
        check("post_rst_spins", 64'(bus.spins), 64'hD);
        check("post_rst_run_count", 64'(bus.run_count), 64'd1);
        check("post_rst_best_energy", 64'(bus.best_energy), 64'h0000_0001_0000);

        // clear_best in FINISH wins over recording; overrun from this run is cleared too.
        run_window(3, 7, lat, pulses, busy_err);
        check("clr_pulses", 64'(pulses), 64'd1);
        check("clr_energy", 64'(bus.energy), 64'h0000_0001_0000);
        check("clr_run_count", 64'(bus.run_count), 64'd2);
        check("clr_best_valid", 64'(bus.best_valid), 64'h0);
        check("clr_best_energy", 64'(bus.best_energy), 64'h7FFF_FFFF_FFFF);
        check("clr_best_spins", 64'(bus.best_spins), 64'h0);
        check("clr_overrun", 64'(bus.overrun), 64'h0);

        // Equal-energy repeat records because nothing is held as best.
        run_window(-1, -1, lat, pulses, busy_err);
        check("tie_best_valid", 64'(bus.best_valid), 64'h1);
        check("tie_best_energy", 64'(bus.best_energy), 64'h0000_0001_0000);
        check("tie_best_spins", 64'(bus.best_spins), 64'hD);
        check("tie_run_count", 64'(bus.run_count), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
